pipe_fetch_stage: RTL and testbench
===================================

Name: pipe_fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage pipelined MIPS core; sits directly upstream of the ID control/decode stage.
- Holds the PC and selects the next PC from the ID stage's `pcsource`/targets.
- Fetches from a variable-latency instruction memory through a req/ack handshake and delivers {`dpc4`, `inst`} to ID.
- Honours the ID stall (`wpcir`) and inserts bubbles on memory wait; branch delay slot semantics (ID-resolved branches).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word injected into IF/ID as a bubble (sll $0,$0,0).

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pcsource  in  2  from ID: 00 = pc+4, 01 = branch (`bpc`), 10 = jr (`da`), 11 = jump (`jpc`).
- bpc  in  32  branch target from ID.
- da  in  32  forwarded rs value from ID (jr target).
- jpc  in  32  jump target from ID.
- wpcir  in  1  1 = ID accepts/advances this cycle; 0 = load-use stall.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals `pc`.
- imem_ack  in  1  read data valid this cycle; may assert in the same cycle as `imem_req`.
- imem_rdata  in  32  instruction word, valid when `imem_ack`=1.
- pc  out  32  current fetch PC.
- dpc4  out  32  IF/ID register: PC+4 of the instruction in ID.
- inst  out  32  IF/ID register: instruction in ID.

Behaviour:
- Reset (async):
  - `pc`=RESET_PC, `dpc4`=0, `inst`=NOP_INST.
  - state=FETCH, `redir_pend`=0, `redir_tgt`=0, `hold_inst`=0.
  - `imem_req` is 0 while reset is asserted.
  - First request is issued in the first cycle after reset deasserts.
- States: FETCH (request outstanding), HOLD (instruction captured, ID stalled). One request outstanding at most.
- `imem_req` = (state==FETCH). `imem_addr` = `pc`, stable until ack.
- Next-PC target (combinational):
  - `redir_pend`=1 → `redir_tgt`.
  - Otherwise by `pcsource`: 00 → `pc`+4; 01 → `bpc`; 10 → `da`; 11 → `jpc`.
  - All adds are 32-bit, wrap modulo 2^32.
- Redirect capture: if `wpcir`=1, `pcsource`≠00, and the PC is NOT updated this cycle, then `redir_pend`←1 and `redir_tgt`←selected target. `redir_pend` clears whenever `pc` is updated.
- FETCH, `imem_ack`=1, `wpcir`=1:
  - `dpc4`←`pc`+4, `inst`←`imem_rdata`, `pc`←target.
  - Stay in FETCH. Zero-wait memory gives one instruction per cycle.
- FETCH, `imem_ack`=1, `wpcir`=0:
  - `hold_inst`←`imem_rdata`. Go to HOLD.
  - IF/ID and `pc` are unchanged.
- FETCH, `imem_ack`=0, `wpcir`=1:
  - `inst`←NOP_INST (bubble); `dpc4` unchanged.
  - `pc` unchanged; redirect capture applies.
- FETCH, `imem_ack`=0, `wpcir`=0: nothing changes.
- HOLD, `wpcir`=0: nothing changes; `imem_req`=0.
- HOLD, `wpcir`=1:
  - `dpc4`←`pc`+4, `inst`←`hold_inst`, `pc`←target. Go to FETCH.
- `imem_ack` while `imem_req`=0 is ignored.
- Delay slot: the instruction fetched while a branch or jump is in ID is always delivered. The redirected PC applies to the fetch after it.
- A stalled branch in ID (`wpcir`=0) never updates `pc` or `redir_*`.
- Reset asserted mid-request: the request is abandoned, and any late ack after reset release is treated as the response to the new RESET_PC request. The integrator's memory must therefore drop outstanding requests on reset.

Test Plan:
- Zero-wait sequential: `imem_ack`=1 every cycle, `wpcir`=1, `pcsource`=00, RESET_PC=0 → `imem_addr` 0,4,8,…; `inst` equals the word at the address one cycle earlier; `dpc4`=addr+4.
- Wait states: ack 2 cycles after each req → `inst`=NOP for 2 cycles between real instructions; `imem_addr` stable during the wait; `pc` advances only on ack.
- Load-use stall: ack at `pc`=0x10 with `wpcir`=0 for 2 cycles → state HOLD, `imem_req`=0, IF/ID unchanged. On `wpcir`=1: `inst`=held word, `dpc4`=0x14, next `imem_addr`=0x14.
- Branch with late delay slot: beq in ID (`pcsource`=01, `bpc`=0x100, `wpcir`=1) while the delay-slot fetch at 0x24 has no ack. Ack arrives 3 cycles later → delay-slot word delivered with `dpc4`=0x28; next `imem_addr`=0x100; `redir_pend` cleared.
- jr/jal same-cycle: `pcsource`=10, `da`=0x4000 with ack present → next `imem_addr`=0x4000. Repeat with `pcsource`=11, `jpc`=0x0800 → 0x0800.
- Reset mid-fetch: assert reset while waiting on ack at 0x30 → immediately `pc`=RESET_PC, `inst`=NOP, `dpc4`=0, `imem_req`=0. After release, `imem_req`=1 with `imem_addr`=RESET_PC.

Source files
------------

// File: rtl/pipe_fetch_stage_if.sv
// Instruction-memory fetch handshake between the IF stage and imem.
// One request outstanding at most; ack may come in the request cycle.
interface pipe_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pipe_fetch_stage.sv
// IF stage plus IF/ID register for the 5-stage MIPS pipeline.
// Variable-latency fetch, ID stall honouring, ID-resolved branches.
module pipe_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          pcsource,
    input  logic [31:0]         bpc,
    input  logic [31:0]         da,
    input  logic [31:0]         jpc,
    input  logic                wpcir,
    pipe_fetch_stage_if.master  imem,
    output logic [31:0]         pc,
    output logic [31:0]         dpc4,
    output logic [31:0]         inst
);

    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]  state;
    logic        redir_pend;
    logic [31:0] redir_tgt;
    logic [31:0] hold_inst;

    logic [31:0] pc4;
    logic [31:0] sel_tgt;
    logic [31:0] next_pc;
    logic        in_fetch;
    logic        ack_fetch;
    logic        pc_upd;
    logic        capture;

    // Request while fetching; suppressed for the whole reset interval.
    always_comb begin
        in_fetch       = (state == FETCH);
        imem.imem_req  = in_fetch && !reset;
        imem.imem_addr = pc;
    end

    // Next-PC selection: a pending redirect beats the live ID request.
    always_comb begin
        pc4     = pc + 32'd4;
        sel_tgt = pc4;
        unique case (pcsource)
            2'b00: sel_tgt = pc4;
            2'b01: sel_tgt = bpc;
            2'b10: sel_tgt = da;
            2'b11: sel_tgt = jpc;
            default: sel_tgt = pc4;
        endcase
        next_pc   = redir_pend ? redir_tgt : sel_tgt;
        ack_fetch = in_fetch && imem.imem_ack;
        pc_upd    = wpcir && (ack_fetch || !in_fetch);
        capture   = wpcir && (pcsource != 2'b00) && !pc_upd;
    end

    // Fetch FSM, PC, IF/ID register and redirect bookkeeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            dpc4       <= 32'h0000_0000;
            inst       <= NOP_INST;
            redir_pend <= 1'b0;
            redir_tgt  <= 32'h0000_0000;
            hold_inst  <= 32'h0000_0000;
        end else begin
            if (in_fetch) begin
                if (imem.imem_ack && wpcir) begin
                    dpc4 <= pc4;
                    inst <= imem.imem_rdata;
                    pc   <= next_pc;
                end else if (imem.imem_ack) begin
                    hold_inst <= imem.imem_rdata;
                    state     <= HOLD;
                end else if (wpcir) begin
                    inst <= NOP_INST;
                end
            end else if (wpcir) begin
                dpc4  <= pc4;
                inst  <= hold_inst;
                pc    <= next_pc;
                state <= FETCH;
            end

            if (pc_upd) begin
                redir_pend <= 1'b0;
            end else if (capture) begin
                redir_pend <= 1'b1;
                redir_tgt  <= next_pc;
            end
        end
    end

endmodule

// File: tb/tb_pipe_fetch_stage.sv
// Directed bench for pipe_fetch_stage: streaming, wait states, stalls,
// delayed delay slot, jr/j redirects, stalled branch and mid-fetch reset.
module tb_pipe_fetch_stage;

    localparam logic [31:0] NOP = 32'hFFFF_0000;

    logic        clock;
    logic        reset;
    logic [1:0]  pcsource;
    logic [31:0] bpc;
    logic [31:0] da;
    logic [31:0] jpc;
    logic        wpcir;
    logic [31:0] pc;
    logic [31:0] dpc4;
    logic [31:0] inst;

    int checks = 0;
    int errors = 0;

    pipe_fetch_stage_if imem ();

    pipe_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (NOP)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .pcsource (pcsource),
        .bpc      (bpc),
        .da       (da),
        .jpc      (jpc),
        .wpcir    (wpcir),
        .imem     (imem.master),
        .pc       (pc),
        .dpc4     (dpc4),
        .inst     (inst)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h1000_0000 ^ (a << 4) ^ a;
    endfunction

    // Memory word for whatever address is presented.
    always_comb imem.imem_rdata = word(imem.imem_addr);

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        pcsource      = 2'b00;
        bpc           = '0;
        da            = '0;
        jpc           = '0;
        wpcir         = 1'b1;
        imem.imem_ack = 1'b0;
        tick();
        tick();
        check("rst_pc", pc, 32'h0);
        check("rst_dpc4", dpc4, 32'h0);
        check("rst_inst", inst, NOP);
        check("rst_req", {31'b0, imem.imem_req}, 32'h0);

        reset = 1'b0;
        #1;
        check("first_req", {31'b0, imem.imem_req}, 32'h1);
        check("first_addr", imem.imem_addr, 32'h0);

        // Zero-wait streaming.
        imem.imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("seq_addr", imem.imem_addr, 32'(4 * i));
            tick();
            check("seq_inst", inst, word(32'(4 * i)));
            check("seq_dpc4", dpc4, 32'(4 * i + 4));
        end

        // Load-use stall while the fetch at 0x10 returns.
        wpcir = 1'b0;
        tick();
        check("hold_req", {31'b0, imem.imem_req}, 32'h0);
        check("hold_inst", inst, word(32'h0C));
        check("hold_dpc4", dpc4, 32'h10);
        tick();
        check("hold2_req", {31'b0, imem.imem_req}, 32'h0);
        check("hold2_pc", pc, 32'h10);
        check("hold2_inst", inst, word(32'h0C));
        wpcir         = 1'b1;
        imem.imem_ack = 1'b0;
        tick();
        check("rel_inst", inst, word(32'h10));
        check("rel_dpc4", dpc4, 32'h14);
        check("rel_addr", imem.imem_addr, 32'h14);
        check("rel_req", {31'b0, imem.imem_req}, 32'h1);

        // Two wait states at 0x14.
        tick();
        check("ws1_inst", inst, NOP);
        check("ws1_addr", imem.imem_addr, 32'h14);
        check("ws1_dpc4", dpc4, 32'h14);
        tick();
        check("ws2_inst", inst, NOP);
        check("ws2_addr", imem.imem_addr, 32'h14);
        imem.imem_ack = 1'b1;
        tick();
        check("ws_inst", inst, word(32'h14));
        check("ws_dpc4", dpc4, 32'h18);
        check("ws_addr", imem.imem_addr, 32'h18);

        // Stream to the branch at 0x20.
        tick();
        tick();
        tick();
        check("br_inst", inst, word(32'h20));
        check("br_addr", imem.imem_addr, 32'h24);

        // Branch in ID, delay-slot fetch at 0x24 not yet acked.
        pcsource      = 2'b01;
        bpc           = 32'h100;
        imem.imem_ack = 1'b0;
        tick();
        check("ds_bubble", inst, NOP);
        check("ds_addr", imem.imem_addr, 32'h24);
        pcsource = 2'b00;
        bpc      = 32'h0;
        tick();
        tick();
        check("ds_wait_addr", imem.imem_addr, 32'h24);
        imem.imem_ack = 1'b1;
        tick();
        check("ds_inst", inst, word(32'h24));
        check("ds_dpc4", dpc4, 32'h28);
        check("ds_tgt", imem.imem_addr, 32'h100);
        tick();
        check("ds_clr", imem.imem_addr, 32'h104);

        // jr then j with ack present.
        tick();
        pcsource = 2'b10;
        da       = 32'h4000;
        tick();
        check("jr_inst", inst, word(32'h108));
        check("jr_dpc4", dpc4, 32'h10C);
        check("jr_addr", imem.imem_addr, 32'h4000);
        pcsource = 2'b11;
        jpc      = 32'h0800;
        tick();
        check("j_inst", inst, word(32'h4000));
        check("j_addr", imem.imem_addr, 32'h0800);

        // A stalled branch must not redirect.
        pcsource      = 2'b01;
        bpc           = 32'h200;
        wpcir         = 1'b0;
        imem.imem_ack = 1'b0;
        tick();
        check("stb_addr", imem.imem_addr, 32'h0800);
        pcsource      = 2'b00;
        wpcir         = 1'b1;
        imem.imem_ack = 1'b1;
        tick();
        check("stb_next", imem.imem_addr, 32'h0804);

        // Jump to 0x30, then reset while waiting on it.
        pcsource = 2'b11;
        jpc      = 32'h30;
        tick();
        check("j30_addr", imem.imem_addr, 32'h30);
        pcsource      = 2'b00;
        imem.imem_ack = 1'b0;
        tick();
        check("j30_wait", imem.imem_addr, 32'h30);
        #2;
        reset = 1'b1;
        #1;
        check("mrst_pc", pc, 32'h0);
        check("mrst_inst", inst, NOP);
        check("mrst_dpc4", dpc4, 32'h0);
        check("mrst_req", {31'b0, imem.imem_req}, 32'h0);
        tick();
        reset = 1'b0;
        #1;
        check("post_req", {31'b0, imem.imem_req}, 32'h1);
        check("post_addr", imem.imem_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
